// File: rtl/ad9854_sweep_ctrl.sv
// rtl/ad9854_sweep_ctrl.sv - frequency-sweep sequencer feeding 48-bit tuning words to the AD9854 driver
//
// Purpose: walks a tuning word from f_start to f_stop in f_step increments,
// offering each word on a valid/ready handshake and holding off for a
// programmable dwell after every accept. Single-shot, sawtooth and
// triangle sweeps are supported.
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   start, abort          begin sweep (IDLE only) / stop immediately (wins over start)
//   mode                  0 single, 1 sawtooth, 2 triangle, 3 single
//   f_start/f_stop/f_step sweep endpoints and unsigned step magnitude
//   dwell                 hold cycles after each accepted word (0 behaves as 1)
//   fw_out, fw_valid      tuning word and its valid flag
//   fw_ready              driver accepts fw_out this cycle
//   busy, done, dir_down  activity, single-sweep completion pulse, current direction
module ad9854_sweep_ctrl #(
  parameter int FW_W    = 48,
  parameter int DWELL_W = 24
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               abort,
  input  logic [1:0]         mode,
  input  logic [FW_W-1:0]    f_start,
  input  logic [FW_W-1:0]    f_stop,
  input  logic [FW_W-1:0]    f_step,
  input  logic [DWELL_W-1:0] dwell,
  output logic [FW_W-1:0]    fw_out,
  output logic               fw_valid,
  input  logic               fw_ready,
  output logic               busy,
  output logic               done,
  output logic               dir_down
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_EMIT  = 3'd1,
    S_DWELL = 3'd2,
    S_STEP  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [FW_W-1:0]    fw_out_q, fw_out_d;
  logic [FW_W-1:0]    start_q, start_d;
  logic [FW_W-1:0]    stop_q, stop_d;
  logic [FW_W-1:0]    step_q, step_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic [1:0]         mode_q, mode_d;
  logic               degen_q, degen_d;
  logic               fw_valid_q, fw_valid_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               dir_down_q, dir_down_d;

  logic [FW_W-1:0]    lo, hi, tgt_cur, tgt_new;
  logic [DWELL_W-1:0] dwell_eff;
  logic               at_tgt;

  // One step toward tgt, computed one bit wider so a carry or borrow out
  // is caught; overshooting the target (or wrapping) lands on the target.
  function automatic logic [FW_W-1:0] step_toward(input logic [FW_W-1:0] cur,
                                                  input logic [FW_W-1:0] stp,
                                                  input logic [FW_W-1:0] tgt,
                                                  input logic            down);
    logic [FW_W:0]   nxt;
    logic [FW_W-1:0] res;
    if (down) begin
      nxt = {1'b0, cur} - {1'b0, stp};
      res = (nxt[FW_W] || (nxt[FW_W-1:0] < tgt)) ? tgt : nxt[FW_W-1:0];
    end else begin
      nxt = {1'b0, cur} + {1'b0, stp};
      res = (nxt[FW_W] || (nxt[FW_W-1:0] > tgt)) ? tgt : nxt[FW_W-1:0];
    end
    return res;
  endfunction

  // The target is always the extreme in the current direction: for single
  // and sawtooth that is f_stop, and in triangle it alternates with f_start.
  assign lo        = (start_q < stop_q) ? start_q : stop_q;
  assign hi        = (start_q < stop_q) ? stop_q : start_q;
  assign tgt_cur   = dir_down_q ? lo : hi;
  assign tgt_new   = dir_down_q ? hi : lo;
  assign at_tgt    = (fw_out_q == tgt_cur);
  assign dwell_eff = (dwell_q == '0) ? DWELL_W'(1) : dwell_q;

  always_comb begin
    state_d    = state_q;
    fw_out_d   = fw_out_q;
    start_d    = start_q;
    stop_d     = stop_q;
    step_d     = step_q;
    dwell_d    = dwell_q;
    cnt_d      = cnt_q;
    mode_d     = mode_q;
    degen_d    = degen_q;
    fw_valid_d = fw_valid_q;
    busy_d     = busy_q;
    done_d     = done_q;
    dir_down_d = dir_down_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          start_d    = f_start;
          stop_d     = f_stop;
          step_d     = f_step;
          dwell_d    = dwell;
          mode_d     = mode;
          degen_d    = (f_step == '0) || (f_start == f_stop);
          fw_out_d   = f_start;
          dir_down_d = (f_start > f_stop);
          fw_valid_d = 1'b1;
          busy_d     = 1'b1;
          state_d    = S_EMIT;
        end
      end
      S_EMIT: begin
        if (fw_valid_q && fw_ready) begin
          fw_valid_d = 1'b0;
          cnt_d      = dwell_eff;
          state_d    = S_DWELL;
        end
      end
      S_DWELL: begin
        if (cnt_q <= DWELL_W'(1)) begin
          cnt_d   = '0;
          state_d = S_STEP;
        end else begin
          cnt_d = cnt_q - DWELL_W'(1);
        end
      end
      S_STEP: begin
        if (degen_q || (at_tgt && (mode_q == 2'd0 || mode_q == 2'd3))) begin
          done_d  = 1'b1;
          state_d = S_DONE;
        end else begin
          fw_valid_d = 1'b1;
          state_d    = S_EMIT;
          if (!at_tgt) begin
            fw_out_d = step_toward(fw_out_q, step_q, tgt_cur, dir_down_q);
          end else if (mode_q == 2'd1) begin
            fw_out_d = start_q;
          end else begin
            // Triangle turn-around: step away from the endpoint at once so
            // it is not offered twice in a row.
            dir_down_d = ~dir_down_q;
            fw_out_d   = step_toward(fw_out_q, step_q, tgt_new, ~dir_down_q);
          end
        end
      end
      S_DONE: begin
        done_d  = 1'b0;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (abort) begin
      state_d    = S_IDLE;
      fw_valid_d = 1'b0;
      busy_d     = 1'b0;
      done_d     = 1'b0;
      cnt_d      = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      fw_out_q   <= '0;
      start_q    <= '0;
      stop_q     <= '0;
      step_q     <= '0;
      dwell_q    <= '0;
      cnt_q      <= '0;
      mode_q     <= '0;
      degen_q    <= 1'b0;
      fw_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      dir_down_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      fw_out_q   <= fw_out_d;
      start_q    <= start_d;
      stop_q     <= stop_d;
      step_q     <= step_d;
      dwell_q    <= dwell_d;
      cnt_q      <= cnt_d;
      mode_q     <= mode_d;
      degen_q    <= degen_d;
      fw_valid_q <= fw_valid_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      dir_down_q <= dir_down_d;
    end
  end

  assign fw_out   = fw_out_q;
  assign fw_valid = fw_valid_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign dir_down = dir_down_q;

endmodule
